// File: rtl/parity_frame_checker.sv
// Serial frame parity checker: FRAME_LEN data bits plus one parity bit per frame,
// with Mealy running parity, per-frame done/error pulses and a saturating error count.
module parity_frame_checker #(
   parameter int unsigned FRAME_LEN  = 8,
   parameter int unsigned ODD_PARITY = 0,
   parameter int unsigned ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 x_valid,
   input  logic                 x,
   input  logic                 start,
   output logic                 parity,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 parity_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int unsigned CntW = $clog2(FRAME_LEN + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_LEN - 1);
   localparam logic Odd = (ODD_PARITY != 0);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DATA  = 2'd1;
   localparam logic [1:0] CHECK = 2'd2;

   logic [1:0]           state_q, state_d;
   logic                 acc_q, acc_d;
   logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
   logic                 done_q, done_d;
   logic                 perr_q, perr_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [1:0]           cur_st;
   logic                 xin;
   logic                 err;

   // start makes the current cycle behave as IDLE with a cleared accumulator
   assign cur_st = start ? IDLE : state_q;
   assign xin    = x & x_valid;
   assign err    = acc_q ^ x ^ Odd;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      perr_d    = 1'b0;
      err_cnt_d = err_cnt_q;
      if (start) begin
         state_d   = IDLE;
         acc_d     = 1'b0;
         bit_cnt_d = '0;
      end
      case (cur_st)
         IDLE: begin
            if (x_valid) begin
               acc_d     = x;
               bit_cnt_d = CntW'(1);
               state_d   = (FRAME_LEN == 1) ? CHECK : DATA;
            end
         end
         DATA: begin
            if (x_valid) begin
               acc_d     = acc_q ^ x;
               bit_cnt_d = bit_cnt_q + CntW'(1);
               if (bit_cnt_q == LastCnt) state_d = CHECK;
            end
         end
         CHECK: begin
            if (x_valid) begin
               done_d    = 1'b1;
               perr_d    = err;
               state_d   = IDLE;
               acc_d     = 1'b0;
               bit_cnt_d = '0;
               if (err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            acc_d     = 1'b0;
            bit_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      parity = 1'b0;
      case (cur_st)
         IDLE:    parity = xin;
         DATA:    parity = acc_q ^ xin;
         CHECK:   parity = acc_q ^ Odd;
         default: parity = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         acc_q     <= 1'b0;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
         perr_q    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
         perr_q    <= perr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign frame_done = done_q;
   assign parity_err = perr_q;
   assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: vector tables over three parameterisations
// plus hand-written Mealy-timing, start-resync and mid-frame-reset sequences.
module tb_parity_frame_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, x_valid, x, start;
   logic [2:0] par_w, busy_w, done_w, perr_w;
   logic [7:0] cnt_even, cnt_odd;
   logic [1:0] cnt_small;

   parity_frame_checker u_even (
      .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .start(start),
      .parity(par_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]),
      .parity_err(perr_w[0]), .err_count(cnt_even)
   );

   parity_frame_checker #(.ODD_PARITY(1)) u_odd (
      .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .start(start),
      .parity(par_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]),
      .parity_err(perr_w[1]), .err_count(cnt_odd)
   );

   parity_frame_checker #(.FRAME_LEN(3), .ERR_CNT_W(2)) u_small (
      .clk(clk), .reset(reset), .x_valid(x_valid), .x(x), .start(start),
      .parity(par_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]),
      .parity_err(perr_w[2]), .err_count(cnt_small)
   );

   typedef struct {
      int         sel;
      logic       vld;
      logic       xb;
      logic       st;
      logic       p;
      logic       busy;
      logic       done;
      logic       err;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [7:0] cnt_of(input int sel);
      if (sel == 0) return cnt_even;
      if (sel == 1) return cnt_odd;
      return {6'b0, cnt_small};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Leaves the bench at posedge+1 with reset released and inputs idle.
   task automatic do_reset(input bit check);
      x_valid = 1'b0; x = 1'b0; start = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      if (check) begin
         chk("rst.parity", {5'b0, par_w}, 8'h00);
         chk("rst.busy",   {5'b0, busy_w}, 8'h00);
         chk("rst.done",   {5'b0, done_w}, 8'h00);
         chk("rst.perr",   {5'b0, perr_w}, 8'h00);
         chk("rst.cnt",    cnt_even | cnt_odd | {6'b0, cnt_small}, 8'h00);
      end
      reset = 1'b1;
   endtask

   function automatic vec_t mk(input int sel, input logic vld, input logic xb, input logic st,
                               input logic p, input logic b, input logic d, input logic e,
                               input logic [7:0] c);
      vec_t v;
      v.sel = sel; v.vld = vld; v.xb = xb; v.st = st; v.p = p;
      v.busy = b; v.done = d; v.err = e; v.cnt = c;
      return v;
   endfunction

   // Frame data listed MSB-first in data[n-1:0]; gap idle cycles follow every data bit.
   task automatic add_frame(input int sel, input int n, input logic [7:0] data, input logic pbit,
                            input logic odd, input int gap, input logic [7:0] cmax,
                            inout logic [7:0] cnt);
      logic acc;
      logic b;
      logic e;
      acc = 1'b0;
      for (int i = 0; i < n; i++) begin
         b   = data[n-1-i];
         acc = acc ^ b;
         tbl.push_back(mk(sel, 1'b1, b, 1'b0, acc, 1'b1, 1'b0, 1'b0, cnt));
         for (int g = 0; g < gap; g++)
            tbl.push_back(mk(sel, 1'b0, g[0], 1'b0, (i == n - 1) ? acc ^ odd : acc,
                             1'b1, 1'b0, 1'b0, cnt));
      end
      e = acc ^ pbit ^ odd;
      if (e && cnt != cmax) cnt = cnt + 8'd1;
      tbl.push_back(mk(sel, 1'b1, pbit, 1'b0, acc ^ odd, 1'b0, 1'b1, e, cnt));
   endtask

   task automatic add_idle(input int sel, input logic [7:0] cnt);
      tbl.push_back(mk(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cnt));
   endtask

   task automatic run_table(input string tag);
      foreach (tbl[i]) begin
         x_valid = tbl[i].vld; x = tbl[i].xb; start = tbl[i].st;
         #1;
         chk($sformatf("%s[%0d].parity", tag, i), {7'b0, par_w[tbl[i].sel]}, {7'b0, tbl[i].p});
         @(posedge clk); #1;
         chk($sformatf("%s[%0d].busy", tag, i), {7'b0, busy_w[tbl[i].sel]}, {7'b0, tbl[i].busy});
         chk($sformatf("%s[%0d].done", tag, i), {7'b0, done_w[tbl[i].sel]}, {7'b0, tbl[i].done});
         chk($sformatf("%s[%0d].perr", tag, i), {7'b0, perr_w[tbl[i].sel]}, {7'b0, tbl[i].err});
         chk($sformatf("%s[%0d].cnt", tag, i), cnt_of(tbl[i].sel), tbl[i].cnt);
      end
      x_valid = 1'b0; x = 1'b0; start = 1'b0;
      tbl.delete();
   endtask

   logic [7:0] cnt;

   initial begin
      reset = 1'b0; x_valid = 1'b0; x = 1'b0; start = 1'b0;

      // Even parity: good frame then back-to-back bad frame.
      do_reset(1'b1);
      cnt = 8'd0;
      add_frame(0, 8, 8'hA5, 1'b0, 1'b0, 0, 8'hFF, cnt);
      add_frame(0, 8, 8'hA5, 1'b1, 1'b0, 0, 8'hFF, cnt);
      add_idle(0, cnt);
      run_table("even");

      // Odd parity.
      do_reset(1'b0);
      cnt = 8'd0;
      add_frame(1, 8, 8'hA5, 1'b1, 1'b1, 0, 8'hFF, cnt);
      add_frame(1, 8, 8'hA5, 1'b0, 1'b1, 0, 8'hFF, cnt);
      add_idle(1, cnt);
      run_table("odd");

      // 3-cycle valid gaps after every bit.
      do_reset(1'b0);
      cnt = 8'd0;
      add_frame(0, 8, 8'hA5, 1'b0, 1'b0, 3, 8'hFF, cnt);
      add_idle(0, cnt);
      run_table("gap");

      // Saturating 2-bit counter, five bad 3-bit frames back to back.
      do_reset(1'b0);
      cnt = 8'd0;
      for (int f = 0; f < 5; f++) add_frame(2, 3, 8'b110, 1'b1, 1'b0, 0, 8'd3, cnt);
      add_idle(2, cnt);
      run_table("sat");

      // Mealy timing in DATA, x-independence in CHECK.
      do_reset(1'b0);
      x_valid = 1'b1; x = 1'b1;
      @(posedge clk); #1;
      x = 1'b0; #1;
      chk("mealy.pre", {7'b0, par_w[0]}, 8'h01);
      x = 1'b1; #1;
      chk("mealy.post", {7'b0, par_w[0]}, 8'h00);
      @(posedge clk); #1;
      x = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      x_valid = 1'b0; #1;
      chk("check.x0", {7'b0, par_w[0]}, 8'h00);
      x = 1'b1; #1;
      chk("check.x1", {7'b0, par_w[0]}, 8'h00);
      x_valid = 1'b1; #1;
      chk("check.v1", {7'b0, par_w[0]}, 8'h00);
      chk("check.busy", {7'b0, busy_w[0]}, 8'h01);
      @(posedge clk); #1;
      x_valid = 1'b0; x = 1'b0;
      chk("check.done", {7'b0, done_w[0]}, 8'h01);
      chk("check.perr", {7'b0, perr_w[0]}, 8'h01);
      chk("check.cnt", cnt_even, 8'd1);

      // start after five data bits resynchronises the frame.
      do_reset(1'b0);
      x_valid = 1'b1; x = 1'b1;
      repeat (5) begin @(posedge clk); #1; end
      start = 1'b1; #1;
      chk("start.parity", {7'b0, par_w[0]}, 8'h01);
      @(posedge clk); #1;
      start = 1'b0;
      chk("start.busy", {7'b0, busy_w[0]}, 8'h01);
      chk("start.done", {7'b0, done_w[0]}, 8'h00);
      x = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         chk($sformatf("start.nodone%0d", i), {7'b0, done_w[0]}, 8'h00);
      end
      x = 1'b1; #1;
      chk("start.exp_par", {7'b0, par_w[0]}, 8'h01);
      @(posedge clk); #1;
      x_valid = 1'b0; x = 1'b0;
      chk("start.fdone", {7'b0, done_w[0]}, 8'h01);
      chk("start.fperr", {7'b0, perr_w[0]}, 8'h00);
      chk("start.cnt", cnt_even, 8'd0);

      // Asynchronous reset mid-frame.
      x_valid = 1'b1; x = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b0; #1;
      chk("mrst.busy", {7'b0, busy_w[0]}, 8'h00);
      x_valid = 1'b0; x = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("mrst.done%0d", i), {7'b0, done_w[0]}, 8'h00);
         chk($sformatf("mrst.busy%0d", i), {7'b0, busy_w[0]}, 8'h00);
      end
      cnt = 8'd0;
      add_frame(0, 8, 8'hA5, 1'b0, 1'b0, 0, 8'hFF, cnt);
      run_table("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
